// File: rtl/select4_arbiter_if.sv
// Bundle for the shared 4:1 select path: requests and data in,
// grant, order code and registered data out.
interface select4_arbiter_if #(
    parameter int WIDTH = 32
);
    logic [3:0]       req;
    logic [WIDTH-1:0] in_data1;
    logic [WIDTH-1:0] in_data2;
    logic [WIDTH-1:0] in_data3;
    logic [WIDTH-1:0] in_data4;
    logic [3:0]       grant;
    logic [1:0]       order;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             busy;
    logic             timeout;

    modport master (
        output req,
        output in_data1,
        output in_data2,
        output in_data3,
        output in_data4,
        input  grant,
        input  order,
        input  out_data,
        input  out_valid,
        input  busy,
        input  timeout
    );

    modport slave (
        input  req,
        input  in_data1,
        input  in_data2,
        input  in_data3,
        input  in_data4,
        output grant,
        output order,
        output out_data,
        output out_valid,
        output busy,
        output timeout
    );
endinterface

// File: rtl/select4_arbiter.sv
// Round-robin arbiter/sequencer for the shared 4:1 select path.
// Optional hold-time limit enabled by defining ARB_TIMEOUT_EN.
module select4_arbiter #(
    parameter int WIDTH    = 32,
    parameter int MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    select4_arbiter_if.slave   bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [3:0]       grant_q, grant_d;
    logic [1:0]       order_q, order_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    logic [3:0]       req_eff;
    logic             pick_found;
    logic [1:0]       pick_idx;
    logic [1:0]       cand;
    logic [WIDTH-1:0] sel_data;
    logic             hold_req;
    logic             force_rel;

    assign hold_req = bus.req[order_q];

`ifdef ARB_TIMEOUT_EN
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          timeout_q, timeout_d;
    // Requesters that timed out stay masked until they drop req.
    logic [3:0]    blocked_q, blocked_d;

    assign force_rel = hold_req && (hold_cnt_q == HW'(MAX_HOLD - 1));
    assign req_eff   = bus.req & ~blocked_q;
`else
    assign force_rel = 1'b0;
    assign req_eff   = bus.req;
`endif

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = ptr_q;
        cand       = ptr_q;
        // Scan farthest-first so the slot closest to ptr wins.
        for (int k = 3; k >= 0; k--) begin
            cand = ptr_q + 2'(k);
            if (req_eff[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        sel_data = bus.in_data1;
        unique case (order_q)
            2'd0: sel_data = bus.in_data1;
            2'd1: sel_data = bus.in_data2;
            2'd2: sel_data = bus.in_data3;
            2'd3: sel_data = bus.in_data4;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        order_d     = order_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
`ifdef ARB_TIMEOUT_EN
        hold_cnt_d  = hold_cnt_q;
        timeout_d   = 1'b0;
        blocked_d   = blocked_q & bus.req;
`endif
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = GRANT;
                    grant_d = 4'b0001 << pick_idx;
                    order_d = pick_idx;
                    busy_d  = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    hold_cnt_d = '0;
`endif
                end
            end
            GRANT: begin
                if (!hold_req || force_rel) begin
                    state_d     = IDLE;
                    grant_d     = 4'b0000;
                    busy_d      = 1'b0;
                    out_valid_d = 1'b0;
                    ptr_d       = order_q + 2'd1;
`ifdef ARB_TIMEOUT_EN
                    timeout_d = force_rel;
                    if (force_rel) begin
                        blocked_d[order_q] = 1'b1;
                    end
`endif
                end else begin
                    out_data_d  = sel_data;
                    out_valid_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    hold_cnt_d = hold_cnt_q + HW'(1);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= 2'd0;
            grant_q     <= 4'b0000;
            order_q     <= 2'd0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            order_q     <= order_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
            blocked_q  <= 4'b0000;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
            blocked_q  <= blocked_d;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

    assign bus.grant     = grant_q;
    assign bus.order     = order_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;

endmodule
